// File: rtl/cam_pixel_capture_pkg.sv
// rtl/cam_pixel_capture_pkg.sv - shared geometry defaults, widths and FSM states for the camera capture block
package cam_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int FB_DEPTH     = H_ACTIVE_DEF * V_ACTIVE_DEF;
    localparam int ADDR_W       = 19;
    localparam int PIX_W        = 12;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        CAPTURE
    } cap_state_t;

    // Second RGB444 byte carries GGGGBBBB; the pixel word is stored as {B, G, R}.
    function automatic logic [PIX_W-1:0] rgb444_pack(input logic [7:0] hi_byte, input logic [3:0] red);
        return {hi_byte[3:0], hi_byte[7:4], red};
    endfunction

endpackage

// File: rtl/cam_pixel_capture_if.sv
// rtl/cam_pixel_capture_if.sv - camera input bus plus frame-buffer write port
interface cam_pixel_capture_if;
    import cam_pkg::*;

    logic              cam_pclk;
    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_d;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  dout;

    modport master (
        input  cam_pclk, cam_vsync, cam_href, cam_d,
        output we, addr, dout
    );

    modport slave (
        output cam_pclk, cam_vsync, cam_href, cam_d,
        input  we, addr, dout
    );

endinterface

// File: rtl/cam_pixel_capture_sync_edge.sv
// rtl/cam_pixel_capture_sync_edge.sv - 2-flop synchronizer with edge detect against the last enabled sample
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    input  logic sample_en,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // prev_q only advances on sample_en, so edges are relative to the previous camera sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            if (sample_en) begin
                prev_q <= sync_q;
            end
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/cam_pixel_capture.sv
// rtl/cam_pixel_capture.sv - oversampled camera capture: RGB444 byte pairs to frame-buffer writes
module cam_pixel_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic                clk,
    input  logic                reset,
    cam_pixel_capture_if.master cam,
    input  logic                capture_en,
    output logic                frame_done,
    output logic [7:0]          frame_count,
    output logic                line_err
);

    localparam logic [ADDR_W-1:0] H_MAX = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] V_MAX = ADDR_W'(V_ACTIVE);

    cap_state_t state, state_nxt;

    logic sample;
    logic pclk_level_unused, pclk_fall_unused;
    logic vs_level_unused, vs_rise, vs_fall;
    logic hr_s, hr_rise, hr_fall;
    logic [7:0] d_meta, d_sync;

    logic [ADDR_W-1:0] col, row, row_base;
    logic              line_ovf;
    logic              phase, phase_eff;
    logic [3:0]        red_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PIX_W-1:0]  dout_q;

    logic start_frame, end_frame, byte_ev, line_end, r_ev, pix_ev;

    sync_edge u_sync_pclk (
        .clk(clk), .reset(reset), .async_in(cam.cam_pclk), .sample_en(1'b1),
        .sync_out(pclk_level_unused), .rise(sample), .fall(pclk_fall_unused)
    );

    sync_edge u_sync_vsync (
        .clk(clk), .reset(reset), .async_in(cam.cam_vsync), .sample_en(sample),
        .sync_out(vs_level_unused), .rise(vs_rise), .fall(vs_fall)
    );

    sync_edge u_sync_href (
        .clk(clk), .reset(reset), .async_in(cam.cam_href), .sample_en(sample),
        .sync_out(hr_s), .rise(hr_rise), .fall(hr_fall)
    );

    // Data takes the same two-flop path as pclk so it lines up with the sample cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_meta <= '0;
            d_sync <= '0;
        end else begin
            d_meta <= cam.cam_d;
            d_sync <= d_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        byte_ev     = 1'b0;
        line_end    = 1'b0;
        if (sample) begin
            case (state)
                IDLE: begin
                    if (capture_en) begin
                        state_nxt = WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (vs_fall) begin
                        state_nxt   = CAPTURE;
                        start_frame = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        state_nxt = IDLE;
                        end_frame = 1'b1;
                    end else begin
                        byte_ev  = hr_s;
                        line_end = hr_fall && (col != '0);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign phase_eff = hr_rise ? 1'b0 : phase;
    assign r_ev      = byte_ev & ~phase_eff;
    assign pix_ev    = byte_ev & phase_eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            col         <= '0;
            row         <= '0;
            row_base    <= '0;
            line_ovf    <= 1'b0;
            phase       <= 1'b0;
            red_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            line_err    <= 1'b0;
        end else begin
            we_q       <= 1'b0;
            frame_done <= 1'b0;
            if (start_frame) begin
                col      <= '0;
                row      <= '0;
                row_base <= '0;
                line_ovf <= 1'b0;
                phase    <= 1'b0;
            end
            if (r_ev) begin
                red_q <= d_sync[3:0];
                phase <= 1'b1;
            end
            if (pix_ev) begin
                phase <= 1'b0;
                if (col < H_MAX) begin
                    col <= col + ADDR_W'(1);
                    if (row < V_MAX) begin
                        we_q   <= 1'b1;
                        addr_q <= row_base + col;
                        dout_q <= rgb444_pack(d_sync, red_q);
                    end
                end else begin
                    // col saturates, so overlong lines are remembered separately for line_err.
                    line_ovf <= 1'b1;
                end
            end
            if (line_end) begin
                col      <= '0;
                line_ovf <= 1'b0;
                if (row < V_MAX) begin
                    row      <= row + ADDR_W'(1);
                    row_base <= row_base + H_MAX;
                end
                if ((col != H_MAX) || line_ovf) begin
                    line_err <= 1'b1;
                end
            end
            if (end_frame) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    assign cam.we   = we_q;
    assign cam.addr = addr_q;
    assign cam.dout = dout_q;

endmodule
